// File: rtl/traffic_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_ctrl -- two-road intersection controller with pedestrian crossing.
//
// Main road rests in green. It yields to the side road only when the main-road
// minimum green has expired and either a side-road vehicle is present or a
// pedestrian request is pending. The pedestrian walk phase runs alongside the
// side-road green. Each phase lasts a fixed number of cycles, set by a
// parameter.
//
// Parameters
//   MIN_GREEN   minimum main-road green, cycles (1..255)
//   SIDE_GREEN  side-road green, cycles (1..255)
//   YEL         yellow for either road, cycles (1..255)
//   ALLRED      all-red clearance, cycles (1..255)
//
// Ports
//   clk       in   clock, rising-edge active
//   rst       in   asynchronous reset, active-low
//   side_car  in   side-road vehicle sensor (level)
//   ped_req   in   pedestrian request (pulse of one or more cycles)
//   main_lt   out  main-road lamps {R,Y,G}, one-hot
//   side_lt   out  side-road lamps {R,Y,G}, one-hot
//   ped_walk  out  walk indication (high for the whole side-road green)
//   ped_pend  out  pedestrian request latched, not yet served
//   phase     out  current state code, for debug
// -----------------------------------------------------------------------------
module traffic_ctrl #(
  parameter int MIN_GREEN  = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YEL        = 3,
  parameter int ALLRED     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       ped_walk,
  output logic       ped_pend,
  output logic [2:0] phase
);

  // Phase codes are visible on the debug port and must not be re-encoded.
  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  // Lamp patterns, bit order {R,Y,G}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // The counter holds (duration - 1) on entry and counts down to zero, so a
  // phase of duration N occupies exactly N cycles.
  localparam logic [7:0] LOAD_MG   = 8'(MIN_GREEN - 1);
  localparam logic [7:0] LOAD_SG   = 8'(SIDE_GREEN - 1);
  localparam logic [7:0] LOAD_YEL  = 8'(YEL - 1);
  localparam logic [7:0] LOAD_AR   = 8'(ALLRED - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg,   cnt_next;
  logic       pend_reg,  pend_next;

  // ---------------------------------------------------------------------------
  // State register. Reset is treated as an entry into main green.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MG;
      cnt_reg   <= LOAD_MG;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. While the counter is running the state is frozen; the
  // only conditional exit is from main green, which otherwise parks with the
  // counter held at zero so a later request is served on the very edge it is
  // seen.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      MG: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else if (side_car || pend_reg) begin
          state_next = MY;
          cnt_next   = LOAD_YEL;
        end
      end
      MY: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          state_next = AR1;
          cnt_next   = LOAD_AR;
        end
      end
      AR1: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          state_next = SG;
          cnt_next   = LOAD_SG;
        end
      end
      SG: begin
        // Fixed length: side_car is deliberately ignored here.
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          state_next = SY;
          cnt_next   = LOAD_YEL;
        end
      end
      SY: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          state_next = AR2;
          cnt_next   = LOAD_AR;
        end
      end
      AR2: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          state_next = MG;
          cnt_next   = LOAD_MG;
        end
      end
      default: begin
        // Unused codes (upset or glitch) fall back to a full main green.
        state_next = MG;
        cnt_next   = LOAD_MG;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pedestrian latch. A request is held until the walk phase starts. The
  // entry into side green serves it, and that clear beats a request arriving
  // on the same edge, because the walker is being served right then.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_next = pend_reg | ped_req;
    if ((state_next == SG) && (state_reg != SG)) begin
      pend_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs, decoded from the state register only. Anything not
  // explicitly a go/caution phase shows red on both roads.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_lt  = LAMP_R;
    side_lt  = LAMP_R;
    ped_walk = 1'b0;
    case (state_reg)
      MG: main_lt = LAMP_G;
      MY: main_lt = LAMP_Y;
      SG: begin
        side_lt  = LAMP_G;
        ped_walk = 1'b1;
      end
      SY: side_lt = LAMP_Y;
      default: begin
        main_lt  = LAMP_R;
        side_lt  = LAMP_R;
        ped_walk = 1'b0;
      end
    endcase
  end

  assign ped_pend = pend_reg;
  assign phase    = state_reg;

endmodule

// File: tb/tb_traffic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_ctrl -- self-checking bench for traffic_ctrl.
//
// The driver applies inputs, then advances a behavioural model: each phase has
// a duration taken from a table, and the model counts the cycles spent in that
// phase. After every rising edge the expected outputs go into a queue. A
// monitor on the falling edge pops each entry and compares it with the DUT.
// Directed scenarios also check the event timings (transition edges, walk
// length) against fixed constants.
// -----------------------------------------------------------------------------
module tb_traffic_ctrl;

  localparam int MIN_GREEN  = 8;
  localparam int SIDE_GREEN = 6;
  localparam int YEL        = 3;
  localparam int ALLRED     = 1;

  logic       clk;
  logic       rst;
  logic       side_car;
  logic       ped_req;
  logic [2:0] main_lt;
  logic [2:0] side_lt;
  logic       ped_walk;
  logic       ped_pend;
  logic [2:0] phase;

  traffic_ctrl #(
    .MIN_GREEN (MIN_GREEN),
    .SIDE_GREEN(SIDE_GREEN),
    .YEL       (YEL),
    .ALLRED    (ALLRED)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .side_car(side_car),
    .ped_req (ped_req),
    .main_lt (main_lt),
    .side_lt (side_lt),
    .ped_walk(ped_walk),
    .ped_pend(ped_pend),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------------------------------------------------------------------
  // Safety properties, checked on every rising edge.
  // ---------------------------------------------------------------------------
  assert property (@(posedge clk)
      $onehot(main_lt) && $onehot(side_lt) &&
      !(((main_lt & 3'b011) != 3'b000) && ((side_lt & 3'b011) != 3'b000)))
    else begin
      fails++;
      $display("FAIL lamp_safety main_lt=%b side_lt=%b", main_lt, side_lt);
    end

  // ---------------------------------------------------------------------------
  // Reference model: phase index, cycles spent in the phase, pending flag.
  // ---------------------------------------------------------------------------
  int dur [6] = '{MIN_GREEN, YEL, ALLRED, SIDE_GREEN, YEL, ALLRED};
  int m_phase;
  int m_elapsed;
  bit m_pend;

  logic [10:0] exp_q[$];

  function automatic logic [10:0] model_out();
    logic [2:0] mn, sd;
    mn = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    sd = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    return {3'(m_phase), mn, sd, (m_phase == 3), m_pend};
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_pend    = 1'b0;
  endtask

  task automatic model_step(input bit sc, input bit pr);
    bit advance;
    bit new_pend;
    advance  = 1'b0;
    new_pend = m_pend | pr;
    if (m_elapsed < dur[m_phase] - 1) begin
      m_elapsed++;
    end else if (m_phase == 0 && !(sc || m_pend)) begin
      advance = 1'b0;               // main green parks until there is demand
    end else begin
      advance = 1'b1;
    end
    if (advance) begin
      m_phase   = (m_phase + 1) % 6;
      m_elapsed = 0;
      if (m_phase == 3) new_pend = 1'b0;   // walk starts: request served
    end
    m_pend = new_pend;
    exp_q.push_back(model_out());
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare each expected entry against the DUT on the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      logic [10:0] got;
      e   = exp_q.pop_front();
      got = {phase, main_lt, side_lt, ped_walk, ped_pend};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got phase=%0d main=%b side=%b walk=%b pend=%b expected phase=%0d main=%b side=%b walk=%b pend=%b",
                 $time, got[10:8], got[7:5], got[4:2], got[1], got[0],
                 e[10:8], e[7:5], e[4:2], e[1], e[0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers.
  // ---------------------------------------------------------------------------
  int         edge_n;
  logic [2:0] last_phase;
  int         trans_q[$];
  int         phase_seq[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, and log
  // phase changes with the edge number since reset release.
  task automatic cycle(input bit sc, input bit pr);
    side_car = sc;
    ped_req  = pr;
    @(posedge clk);
    model_step(sc, pr);
    edge_n++;
    #1;
    if (phase != last_phase) begin
      trans_q.push_back(edge_n);
      phase_seq.push_back(int'(phase));
      last_phase = phase;
    end
  endtask

  // Assert reset between edges and check the outputs before any clock edge,
  // then release it on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst      = 1'b0;
    side_car = 1'b0;
    ped_req  = 1'b0;
    #1;
    check("reset_out", int'({phase, main_lt, side_lt, ped_walk, ped_pend}),
          int'({3'd0, 3'b001, 3'b100, 1'b0, 1'b0}));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    edge_n     = 0;
    last_phase = 3'd0;
    trans_q.delete();
    phase_seq.delete();
  endtask

  function automatic int trans_at(input int i);
    return (trans_q.size() > i) ? trans_q[i] : -1;
  endfunction

  function automatic int phase_at(input int i);
    return (phase_seq.size() > i) ? phase_seq[i] : -1;
  endfunction

  // Hard bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  int exp_edges  [6] = '{8, 11, 12, 18, 21, 22};
  int exp_phases [6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    int bad;
    int walk_cnt;
    int walk_first;
    rst      = 1'b0;
    side_car = 1'b0;
    ped_req  = 1'b0;
    model_reset();
    edge_n     = 0;
    last_phase = 3'd0;

    // Full cycle with a side car present from release.
    do_reset();
    repeat (22) cycle(1'b1, 1'b0);
    check("s1_transitions", trans_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_edge%0d", i), trans_at(i), exp_edges[i]);
      check($sformatf("s1_phase%0d", i), phase_at(i), exp_phases[i]);
    end

    // Idle main green: no demand for 100 cycles, then demand is served on the
    // very edge it is seen (the counter parked at zero without wrapping).
    do_reset();
    bad = 0;
    repeat (100) begin
      cycle(1'b0, 1'b0);
      if (phase != 3'd0 || main_lt != 3'b001) bad++;
    end
    check("s2_idle_hold", bad, 0);
    cycle(1'b1, 1'b0);
    check("s2_immediate_my", int'(phase), 1);

    // Side car rising on edge 30 with main green idle.
    do_reset();
    repeat (29) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("s4_my_edge30", int'(phase), 1);
    repeat (3) cycle(1'b0, 1'b0);
    check("s4_ar1_edge33", int'(phase), 2);
    check("s4_ar1_first_edge", trans_at(1), 33);

    // One-cycle pedestrian pulse on edge 2.
    do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("s3_pend_edge2", int'(ped_pend), 1);
    walk_cnt   = 0;
    walk_first = -1;
    for (int e = 3; e <= 30; e++) begin
      cycle(1'b0, 1'b0);
      if (e == 8)  check("s3_my_edge8", int'(phase), 1);
      if (e == 12) check("s3_pend_clr_edge12", int'(ped_pend), 0);
      if (ped_walk) begin
        walk_cnt++;
        if (walk_first < 0) walk_first = e;
      end
    end
    check("s3_walk_first", walk_first, 12);
    check("s3_walk_len", walk_cnt, 6);

    // Request on the edge entering SG is absorbed; a request during SY forces
    // the next yield once main green's minimum has run.
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      cycle(e <= 8, (e == 12) || (e == 19));
      if (e == 12) check("s5_clear_wins", int'(ped_pend), 0);
      if (e == 19) check("s5_pend_in_sy", int'(ped_pend), 1);
    end
    check("s5_mg_return", trans_at(5), 22);
    check("s5_forced_my", trans_at(6), 30);
    check("s5_pend_served", int'(ped_pend), 0);

    // Reset in the middle of side green, with a pending request outstanding.
    do_reset();
    for (int e = 1; e <= 14; e++) cycle(1'b1, e == 13);
    check("s6_in_sg", int'(phase), 3);
    check("s6_pend_set", int'(ped_pend), 1);
    do_reset();
    repeat (8) cycle(1'b1, 1'b0);
    check("s6_mg_len", trans_at(0), 8);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
